// File: rtl/row_buf_window_ctrl_pkg.sv
// rtl/row_buf_window_ctrl_pkg.sv - shared state encoding and sizing helpers for the window sequencer
package row_buf_window_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_e;

    // Bits needed to hold 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                bits = i + 1;
            end
        end
        return (bits < 1) ? 1 : bits;
    endfunction

    function automatic int win_count(input int width, input int height, input int win);
        return (width - win + 1) * (height - win + 1);
    endfunction

endpackage

// File: rtl/row_buf_window_ctrl_raster_pos_counter.sv
// rtl/row_buf_window_ctrl_raster_pos_counter.sv - raster col/row tracker with advance, restart and end flags
module raster_pos_counter
    import row_buf_window_ctrl_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int CW     = clog2_min1(WIDTH),
    parameter int RW     = clog2_min1(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] cur_col,
    output logic [RW-1:0] cur_row,
    output logic          at_origin,
    output logic          eof
);
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          eol;

    // cur_* is the position of the pixel being presented; clr makes it (0,0).
    always_comb begin
        cur_col   = clr ? '0 : col_q;
        cur_row   = clr ? '0 : row_q;
        at_origin = (col_q == '0) && (row_q == '0);
        eol       = (cur_col == CW'(WIDTH - 1));
        eof       = eol && (cur_row == RW'(HEIGHT - 1));
        col_d     = cur_col;
        row_d     = cur_row;
        if (en) begin
            if (eol) begin
                col_d = '0;
                row_d = eof ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/row_buf_window_ctrl.sv
// rtl/row_buf_window_ctrl.sv - raster sequencer, shift gating and window-valid tracking for the row-buffer chain
module row_buf_window_ctrl
    import row_buf_window_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int WIN          = 3
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    input  logic                                in_sof,
    input  logic [DATA_WIDTH-1:0]               in_data,
    output logic                                in_ready,
    output logic                                buf_en,
    output logic [DATA_WIDTH-1:0]               buf_din,
    output logic                                win_valid,
    output logic [clog2_min1(IMAGE_WIDTH)-1:0]  win_col,
    output logic [clog2_min1(IMAGE_HEIGHT)-1:0] win_row,
    output logic                                frame_done,
    output logic                                sof_err
);
    localparam int CW   = clog2_min1(IMAGE_WIDTH);
    localparam int RW   = clog2_min1(IMAGE_HEIGHT);
    localparam int HALF = (WIN - 1) / 2;

    ctrl_state_e           state_q, state_d;
    logic                  take, restart, at_origin, eof;
    logic [CW-1:0]         cur_col;
    logic [RW-1:0]         cur_row;
    logic                  buf_en_q, buf_en_d;
    logic [DATA_WIDTH-1:0] buf_din_q, buf_din_d;
    logic [CW-1:0]         pos_col_q, pos_col_d;
    logic [RW-1:0]         pos_row_q, pos_row_d;
    logic                  win_valid_q, win_valid_d;
    logic [CW-1:0]         win_col_q, win_col_d;
    logic [RW-1:0]         win_row_q, win_row_d;
    logic                  done_p1_q, done_p1_d;
    logic                  frame_done_q, frame_done_d;
    logic                  sof_err_q, sof_err_d;

    // In IDLE only a start-of-frame pixel is taken; everything else is dropped.
    always_comb begin
        in_ready = rst_n && (state_q != DONE);
        take     = in_valid && in_ready && ((state_q == RUN) || in_sof);
        restart  = take && in_sof;
    end

    raster_pos_counter #(
        .WIDTH (IMAGE_WIDTH),
        .HEIGHT(IMAGE_HEIGHT),
        .CW    (CW),
        .RW    (RW)
    ) u_pos (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (take),
        .clr      (restart),
        .cur_col  (cur_col),
        .cur_row  (cur_row),
        .at_origin(at_origin),
        .eof      (eof)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = eof ? DONE : RUN;
            RUN:     if (take && eof) state_d = DONE;
            default: state_d = IDLE;
        endcase

        buf_en_d  = take;
        buf_din_d = take ? in_data : buf_din_q;
        pos_col_d = take ? cur_col : pos_col_q;
        pos_row_d = take ? cur_row : pos_row_q;
        sof_err_d = restart && (state_q == RUN) && !at_origin;

        // The chain only holds a full window once the shifted pixel is at least WIN-1 deep in both axes.
        win_valid_d = buf_en_q && (pos_row_q >= RW'(WIN - 1)) && (pos_col_q >= CW'(WIN - 1));
        win_col_d   = win_valid_d ? pos_col_q - CW'(HALF) : win_col_q;
        win_row_d   = win_valid_d ? pos_row_q - RW'(HALF) : win_row_q;

        // DONE is entered one cycle after the last accept; two more stages line it up after the last window.
        done_p1_d    = (state_q == DONE);
        frame_done_d = done_p1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            buf_en_q     <= 1'b0;
            buf_din_q    <= '0;
            pos_col_q    <= '0;
            pos_row_q    <= '0;
            win_valid_q  <= 1'b0;
            win_col_q    <= '0;
            win_row_q    <= '0;
            done_p1_q    <= 1'b0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_en_q     <= buf_en_d;
            buf_din_q    <= buf_din_d;
            pos_col_q    <= pos_col_d;
            pos_row_q    <= pos_row_d;
            win_valid_q  <= win_valid_d;
            win_col_q    <= win_col_d;
            win_row_q    <= win_row_d;
            done_p1_q    <= done_p1_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
        end
    end

    assign buf_en     = buf_en_q;
    assign buf_din    = buf_din_q;
    assign win_valid  = win_valid_q;
    assign win_col    = win_col_q;
    assign win_row    = win_row_q;
    assign frame_done = frame_done_q;
    assign sof_err    = sof_err_q;

endmodule
